prog_clock_divider: RTL and testbench
=====================================

PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, giving the number of independent divider channels (legal range 1..16).
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the counter, period and high-time width in bits (legal range CHANNELS+1..16).
REQ-003 The block SHALL have localparam SEL_W = max(1, clog2(CHANNELS)).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 The ports SHALL be:
- clk  input  1  sole clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- en  input  CHANNELS  per-channel run enable
- sync  input  1  strobe that restarts all channels in phase
- load  input  1  strobe that writes one channel's configuration
- load_ch  input  SEL_W  channel index written by load
- load_div  input  WIDTH  period minus one (period = load_div+1 cycles)
- load_hi  input  WIDTH  high-time in cycles per period
- clk_out  output  CHANNELS  registered divided waveform per channel
- tick  output  CHANNELS  registered one-cycle pulse at start of each period

Function
REQ-006 Each channel i SHALL hold registers div_i, hi_i and cnt_i, all WIDTH bits.
REQ-007 When en[i]=1 and no load, sync or reset affects channel i, each edge SHALL update: cnt_i <= (cnt_i==div_i) ? 0 : cnt_i+1; clk_out[i] <= (cnt_i < hi_i); tick[i] <= (cnt_i==0), all using pre-edge values.
REQ-008 clk_out and tick SHALL lag cnt by exactly one cycle; there SHALL be no combinational path from any input to clk_out or tick.
REQ-009 Comparisons SHALL be unsigned and WIDTH bits wide; cnt_i SHALL never exceed div_i except transiently after a load (see REQ-012).
REQ-010 div_i=0 SHALL give period 1: tick[i]=1 every enabled cycle; clk_out[i]=1 if hi_i>=1, else 0.
REQ-011 hi_i=0 SHALL hold clk_out[i] at 0; hi_i>div_i SHALL hold clk_out[i] at 1 while enabled.
REQ-012 load=1 with load_ch<CHANNELS SHALL, on that edge, set div=load_div, hi=load_hi and cnt=0 for channel load_ch, and drive clk_out and tick for that channel to 0; counting SHALL resume on the next enabled edge.
REQ-013 load=1 with load_ch>=CHANNELS SHALL have no effect.
REQ-014 When en[i]=0, cnt_i and the configuration SHALL hold, and clk_out[i] and tick[i] SHALL be 0 from the next edge; re-enabling SHALL resume from the held cnt_i.
REQ-015 sync=1 SHALL, on that edge, set cnt=0 and clk_out=tick=0 for every channel regardless of en; div and hi SHALL be unchanged.
REQ-016 When load and sync are asserted on the same edge, both SHALL take effect: the addressed channel is reconfigured and all counters are cleared.
REQ-017 Priority SHALL be reset > (load, sync) > en.

Reset
REQ-018 reset=1 SHALL, on the clock edge, set for every channel i: cnt_i=0, clk_out[i]=0, tick[i]=0, div_i=2^(i+1)-1 and hi_i=2^i, giving divide-by-2, 4, 8, 16, ... at 50% duty.
REQ-019 reset SHALL override load, sync and en on the same edge, and reset mid-period SHALL discard the current phase.
REQ-020 The first enabled edge after reset deasserts SHALL produce clk_out[i]=1 and tick[i]=1 for all enabled channels.

Verification
REQ-021 Scenario: reset, then en=4'b1111 for 32 cycles -> clk_out[0..3] toggle with periods 2/4/8/16 at 50% duty; all tick[] high together on cycle 1, and tick[3] every 16 cycles.
REQ-022 Scenario: load ch1, div=4, hi=2 -> clk_out[1] pattern 1,1,0,0,0 repeating, tick[1] every 5 cycles, and the first high appears 2 edges after load.
REQ-023 Scenario: load ch0, div=0, hi=0, then hi=1 -> clk_out[0] constant 0, then constant 1; tick[0] high every cycle in both cases.
REQ-024 Scenario: sync mid-run with mixed ratios -> all outputs 0 the next cycle, then all tick[] high together one cycle later.
REQ-025 Scenario: en[2] dropped for 3 cycles at cnt=5, then restored -> clk_out[2]=tick[2]=0 while disabled, and counting resumes from 5.
REQ-026 Scenario: load with load_ch=CHANNELS, plus load and reset on the same edge -> no configuration change in the first case, and reset defaults in the second.

Source files
------------

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider.
// Each channel has a period/high-time config and registered outputs.
module prog_clock_divider #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    input  logic                load,
    input  logic [SEL_W-1:0]    load_ch,
    input  logic [WIDTH-1:0]    load_div,
    input  logic [WIDTH-1:0]    load_hi,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        localparam logic [WIDTH-1:0] DIV_RST =
            WIDTH'((32'd1 << (i + 1)) - 32'd1);
        localparam logic [WIDTH-1:0] HI_RST =
            WIDTH'(32'd1 << i);

        logic [WIDTH-1:0] div_q;
        logic [WIDTH-1:0] hi_q;
        logic [WIDTH-1:0] cnt_q;
        logic             out_q;
        logic             tick_q;
        logic             hit;

        assign hit = load && (load_ch == SEL_W'(i));

        // Config write, in-phase restart, or one step of the period counter
        always_ff @(posedge clk) begin
            if (reset) begin
                div_q  <= DIV_RST;
                hi_q   <= HI_RST;
                cnt_q  <= '0;
                out_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                if (hit) begin
                    div_q <= load_div;
                    hi_q  <= load_hi;
                end
                if (hit || sync) begin
                    cnt_q  <= '0;
                    out_q  <= 1'b0;
                    tick_q <= 1'b0;
                end else if (en[i]) begin
                    cnt_q  <= (cnt_q == div_q) ? '0 : cnt_q + WIDTH'(1);
                    out_q  <= (cnt_q < hi_q);
                    tick_q <= (cnt_q == '0);
                end else begin
                    out_q  <= 1'b0;
                    tick_q <= 1'b0;
                end
            end
        end

        assign clk_out[i] = out_q;
        assign tick[i]    = tick_q;
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider.
// Table-driven default run plus hand-written corner sequences.
module tb_prog_clock_divider;

    logic       clk;
    logic       reset;
    logic [3:0] en;
    logic       sync;
    logic       load;
    logic [1:0] load_ch;
    logic [7:0] load_div;
    logic [7:0] load_hi;
    logic [3:0] clk_out;
    logic [3:0] tick;

    logic [2:0] en3;
    logic       load3;
    logic [1:0] load_ch3;
    logic [2:0] clk_out3;
    logic [2:0] tick3;

    int total;
    int bad;

    typedef struct {
        logic [3:0] out;
        logic [3:0] tk;
    } vec_t;

    vec_t tbl[16];

    prog_clock_divider #(.CHANNELS(4), .WIDTH(8)) dut (
        .clk(clk), .reset(reset), .en(en), .sync(sync),
        .load(load), .load_ch(load_ch), .load_div(load_div),
        .load_hi(load_hi), .clk_out(clk_out), .tick(tick)
    );

    prog_clock_divider #(.CHANNELS(3), .WIDTH(8)) dut3 (
        .clk(clk), .reset(reset), .en(en3), .sync(1'b0),
        .load(load3), .load_ch(load_ch3), .load_div(8'd0),
        .load_hi(8'd0), .clk_out(clk_out3), .tick(tick3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] got,
                       input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    initial begin
        logic [3:0] ob [10];
        logic [3:0] tb_ [10];
        total = 0;
        bad   = 0;

        tbl[0]  = '{4'b1111, 4'b1111};
        tbl[1]  = '{4'b1110, 4'b0000};
        tbl[2]  = '{4'b1101, 4'b0001};
        tbl[3]  = '{4'b1100, 4'b0000};
        tbl[4]  = '{4'b1011, 4'b0011};
        tbl[5]  = '{4'b1010, 4'b0000};
        tbl[6]  = '{4'b1001, 4'b0001};
        tbl[7]  = '{4'b1000, 4'b0000};
        tbl[8]  = '{4'b0111, 4'b0111};
        tbl[9]  = '{4'b0110, 4'b0000};
        tbl[10] = '{4'b0101, 4'b0001};
        tbl[11] = '{4'b0100, 4'b0000};
        tbl[12] = '{4'b0011, 4'b0011};
        tbl[13] = '{4'b0010, 4'b0000};
        tbl[14] = '{4'b0001, 4'b0001};
        tbl[15] = '{4'b0000, 4'b0000};

        // Reset overrides en and load
        reset = 1'b1; en = 4'b1111; sync = 1'b0;
        load = 1'b1; load_ch = 2'd2; load_div = 8'd3; load_hi = 8'd1;
        en3 = 3'b111; load3 = 1'b0; load_ch3 = 2'd0;
        step();
        step();
        chk("rst_out", clk_out, 4'b0000);
        chk("rst_tick", tick, 4'b0000);
        chk("rst_out3", {1'b0, clk_out3}, 4'b0000);

        // Default ratios; dut3 gets an out-of-range load on edge 1
        reset = 1'b0; load = 1'b0;
        load3 = 1'b1; load_ch3 = 2'd3;
        for (int k = 0; k < 32; k++) begin
            step();
            load3 = 1'b0;
            chk($sformatf("def_out[%0d]", k), clk_out, tbl[k % 16].out);
            chk($sformatf("def_tick[%0d]", k), tick, tbl[k % 16].tk);
            chk($sformatf("oor_out[%0d]", k), {1'b0, clk_out3},
                {1'b0, tbl[k % 16].out[2:0]});
            chk($sformatf("oor_tick[%0d]", k), {1'b0, tick3},
                {1'b0, tbl[k % 16].tk[2:0]});
        end

        // Channel 1 divide-by-5, two cycles high
        load = 1'b1; load_ch = 2'd1; load_div = 8'd4; load_hi = 8'd2;
        step();
        load = 1'b0;
        chk("ld1_out", {3'b0, clk_out[1]}, 4'd0);
        chk("ld1_tick", {3'b0, tick[1]}, 4'd0);
        ob  = '{4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0};
        tb_ = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("d5_out[%0d]", k), {3'b0, clk_out[1]}, ob[k]);
            chk($sformatf("d5_tick[%0d]", k), {3'b0, tick[1]}, tb_[k]);
        end

        // Channel 0 period 1 with hi=0, then hi=1
        for (int h = 0; h < 2; h++) begin
            load = 1'b1; load_ch = 2'd0; load_div = 8'd0;
            load_hi = 8'(h);
            step();
            load = 1'b0;
            chk($sformatf("p1_ld_out[%0d]", h), {3'b0, clk_out[0]}, 4'd0);
            chk($sformatf("p1_ld_tick[%0d]", h), {3'b0, tick[0]}, 4'd0);
            for (int k = 0; k < 4; k++) begin
                step();
                chk($sformatf("p1_out[%0d][%0d]", h, k),
                    {3'b0, clk_out[0]}, 4'(h));
                chk($sformatf("p1_tick[%0d][%0d]", h, k),
                    {3'b0, tick[0]}, 4'd1);
            end
        end

        // Sync mid-run with mixed ratios
        step(); step(); step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("sync_out", clk_out, 4'b0000);
        chk("sync_tick", tick, 4'b0000);
        step();
        chk("sync1_out", clk_out, 4'b1111);
        chk("sync1_tick", tick, 4'b1111);
        step();
        chk("sync2_out", clk_out, 4'b1111);
        chk("sync2_tick", tick, 4'b0001);

        // Ch2 count is now 2; advance to 5, then pause
        step(); step(); step();
        en = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("dis_out[%0d]", k), {3'b0, clk_out[2]}, 4'd0);
            chk($sformatf("dis_tick[%0d]", k), {3'b0, tick[2]}, 4'd0);
        end
        en = 4'b1111;
        ob[0] = 4'd0; ob[1] = 4'd0; ob[2] = 4'd0; ob[3] = 4'd1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("res_out[%0d]", k), {3'b0, clk_out[2]}, ob[k]);
            chk($sformatf("res_tick[%0d]", k), {3'b0, tick[2]}, ob[k]);
        end

        // Load and reset together: reset wins, phase discarded
        reset = 1'b1; load = 1'b1; load_ch = 2'd1;
        load_div = 8'd0; load_hi = 8'd0;
        step();
        reset = 1'b0; load = 1'b0;
        chk("rl_out", clk_out, 4'b0000);
        chk("rl_tick", tick, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("rl_def_out[%0d]", k), clk_out, tbl[k].out);
            chk($sformatf("rl_def_tick[%0d]", k), tick, tbl[k].tk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
